// File: rtl/ps2_host_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : ps2_host_ctrl
// Description : Host-side command sequencer for a PS/2 keyboard port.
//               Issues the keyboard reset command (0xFF) and the set-LEDs
//               command (0xED + LED byte) through the PS/2 transmitter,
//               consumes keyboard replies (0xFA/0xFE/0xAA/0xFC) and retries
//               on resend, line error or reply timeout. All other received
//               bytes are forwarded to the scan-code decoder.
//
// Parameters  : timeoutBits   - width of the reply-wait counter
//               timeoutCycles - clk cycles allowed for a reply
//               maxRetries    - resends allowed per byte before error
//
// Ports       : clk, reset              clock / synchronous active-high reset
//               initReq                 pulse, request keyboard reset sequence
//               ledReq, leds[2:0]       pulse + {caps,num,scroll} LED state
//               rxData[7:0], rxValid    byte stream from the PS/2 receiver
//               txBusy, txDone, txError transmitter status
//               txData[7:0], txStart    byte + start pulse to the transmitter
//               fwdData[7:0], fwdValid  forwarded scan bytes (1-cycle delay)
//               busy                    a command sequence is in progress
//               kbdReady                last reset sequence passed BAT
//               error                   sticky failure flag
//
// Config      : PS2_HOST_AUTOINIT_EN - when defined the init sequence is
//               pending out of reset and starts as soon as reset deasserts.
//
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_host_ctrl #(
    parameter int timeoutBits   = 16,
    parameter int timeoutCycles = 50000,
    parameter int maxRetries    = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       initReq,
    input  logic       ledReq,
    input  logic [2:0] leds,
    input  logic [7:0] rxData,
    input  logic       rxValid,
    input  logic       txBusy,
    input  logic       txDone,
    input  logic       txError,
    output logic [7:0] txData,
    output logic       txStart,
    output logic [7:0] fwdData,
    output logic       fwdValid,
    output logic       busy,
    output logic       kbdReady,
    output logic       error
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [2:0] c_ST_IDLE     = 3'd0;
    localparam logic [2:0] c_ST_SEND     = 3'd1;
    localparam logic [2:0] c_ST_WAIT_TX  = 3'd2;
    localparam logic [2:0] c_ST_WAIT_ACK = 3'd3;
    localparam logic [2:0] c_ST_WAIT_BAT = 3'd4;

    localparam logic [7:0] c_CMD_RESET    = 8'hFF;
    localparam logic [7:0] c_CMD_LED      = 8'hED;
    localparam logic [7:0] c_RSP_ACK      = 8'hFA;
    localparam logic [7:0] c_RSP_RESEND   = 8'hFE;
    localparam logic [7:0] c_RSP_BAT_OK   = 8'hAA;
    localparam logic [7:0] c_RSP_BAT_FAIL = 8'hFC;

    // Retry counter must be able to hold maxRetries itself.
    localparam int c_RETRY_W = (maxRetries > 0) ? $clog2(maxRetries + 1) : 1;
    localparam logic [c_RETRY_W-1:0]   c_MAX_RETRY = c_RETRY_W'(maxRetries);
    localparam logic [timeoutBits-1:0] c_TO_LAST   = timeoutBits'(timeoutCycles - 1);

`ifdef PS2_HOST_AUTOINIT_EN
    localparam logic c_PEND_INIT_RST = 1'b1;
`else
    localparam logic c_PEND_INIT_RST = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [2:0]             r_state;
    logic [7:0]             r_cur;        // byte currently being sent
    logic                   r_isInit;     // 1: init sequence, 0: LED sequence
    logic                   r_ledPhase;   // 0: 0xED outstanding, 1: LED byte
    logic [2:0]             r_ledVal;
    logic                   r_pendInit;
    logic                   r_pendLed;
    logic [c_RETRY_W-1:0]   r_retry;
    logic [timeoutBits-1:0] r_timer;
    logic                   r_kbdReady;
    logic                   r_error;
    logic [7:0]             r_fwdData;
    logic                   r_fwdValid;

    // ------------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------------
    logic w_inAck;
    logic w_inBat;
    logic w_rxAck;
    logic w_rxResend;
    logic w_rxBatOk;
    logic w_rxBatFail;
    logic w_timeout;
    logic w_consume;
    logic w_startInit;
    logic w_startLed;
    logic w_retryEvt;
    logic w_retryOk;

    assign w_inAck     = (r_state == c_ST_WAIT_ACK);
    assign w_inBat     = (r_state == c_ST_WAIT_BAT);
    assign w_rxAck     = rxValid && (rxData == c_RSP_ACK);
    assign w_rxResend  = rxValid && (rxData == c_RSP_RESEND);
    assign w_rxBatOk   = rxValid && (rxData == c_RSP_BAT_OK);
    assign w_rxBatFail = rxValid && (rxData == c_RSP_BAT_FAIL);
    assign w_timeout   = (w_inAck || w_inBat) && (r_timer == c_TO_LAST);

    // Replies are only swallowed in the state that expects them; everything
    // else, including a stray 0xFA while idle, goes to the decoder.
    assign w_consume = (w_inAck && (w_rxAck || w_rxResend)) ||
                       (w_inBat && (w_rxBatOk || w_rxBatFail));

    assign w_startInit = (r_state == c_ST_IDLE) && r_pendInit;
    assign w_startLed  = (r_state == c_ST_IDLE) && !r_pendInit && r_pendLed;

    // A genuine reply in the timeout cycle wins over the timeout.
    assign w_retryEvt = ((r_state == c_ST_WAIT_TX) && !txDone && txError) ||
                        (w_inAck && !w_rxAck && (w_rxResend || w_timeout)) ||
                        (w_inBat && !w_rxBatOk && !w_rxBatFail && w_timeout);
    assign w_retryOk  = (r_retry < c_MAX_RETRY);

    // ------------------------------------------------------------------------
    // Request latches. A new request in the same cycle as the clear keeps
    // the flag set; starting init also drops any pending LED update.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pendInit <= c_PEND_INIT_RST;
            r_pendLed  <= 1'b0;
            r_ledVal   <= 3'b000;
        end else begin
            r_pendInit <= initReq | (r_pendInit & ~w_startInit);
            r_pendLed  <= ledReq  | (r_pendLed  & ~(w_startInit | w_startLed));
            if (ledReq) begin
                r_ledVal <= leds;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= c_ST_IDLE;
            r_cur      <= 8'h00;
            r_isInit   <= 1'b0;
            r_ledPhase <= 1'b0;
            r_retry    <= '0;
            r_timer    <= '0;
            r_kbdReady <= 1'b0;
            r_error    <= 1'b0;
        end else begin
            if (w_inAck || w_inBat) begin
                r_timer <= r_timer + 1'b1;
            end

            if (w_retryEvt) begin
                if (w_retryOk) begin
                    r_retry <= r_retry + 1'b1;
                    r_state <= c_ST_SEND;
                    // A lost BAT means the keyboard missed the reset: redo it.
                    if (w_inBat) begin
                        r_cur <= c_CMD_RESET;
                    end
                end else begin
                    r_error <= 1'b1;
                    if (r_isInit) begin
                        r_kbdReady <= 1'b0;
                    end
                    r_state <= c_ST_IDLE;
                end
            end else begin
                case (r_state)
                    c_ST_IDLE: begin
                        if (w_startInit) begin
                            r_cur      <= c_CMD_RESET;
                            r_isInit   <= 1'b1;
                            r_retry    <= '0;
                            r_error    <= 1'b0;
                            r_kbdReady <= 1'b0;
                            r_state    <= c_ST_SEND;
                        end else if (w_startLed) begin
                            r_cur      <= c_CMD_LED;
                            r_isInit   <= 1'b0;
                            r_ledPhase <= 1'b0;
                            r_retry    <= '0;
                            r_state    <= c_ST_SEND;
                        end
                    end

                    c_ST_SEND: begin
                        if (!txBusy) begin
                            r_state <= c_ST_WAIT_TX;
                        end
                    end

                    c_ST_WAIT_TX: begin
                        if (txDone) begin
                            r_timer <= '0;
                            r_state <= c_ST_WAIT_ACK;
                        end
                    end

                    c_ST_WAIT_ACK: begin
                        if (w_rxAck) begin
                            if (r_isInit) begin
                                r_timer <= '0;
                                r_state <= c_ST_WAIT_BAT;
                            end else if (!r_ledPhase) begin
                                r_cur      <= {5'b00000, r_ledVal};
                                r_ledPhase <= 1'b1;
                                r_retry    <= '0;
                                r_state    <= c_ST_SEND;
                            end else begin
                                r_state <= c_ST_IDLE;
                            end
                        end
                    end

                    c_ST_WAIT_BAT: begin
                        if (w_rxBatOk) begin
                            r_kbdReady <= 1'b1;
                            r_state    <= c_ST_IDLE;
                        end else if (w_rxBatFail) begin
                            r_error    <= 1'b1;
                            r_kbdReady <= 1'b0;
                            r_state    <= c_ST_IDLE;
                        end
                    end

                    default: begin
                        r_state <= c_ST_IDLE;
                    end
                endcase
            end
        end
    end

    // ------------------------------------------------------------------------
    // Receive forwarding (registered, one cycle after rxValid)
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_fwdData  <= 8'h00;
            r_fwdValid <= 1'b0;
        end else begin
            r_fwdValid <= rxValid && !w_consume;
            if (rxValid && !w_consume) begin
                r_fwdData <= rxData;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign txData   = r_cur;
    assign txStart  = (r_state == c_ST_SEND) && !txBusy;
    assign fwdData  = r_fwdData;
    assign fwdValid = r_fwdValid;
    assign busy     = (r_state != c_ST_IDLE);
    assign kbdReady = r_kbdReady;
    assign error    = r_error;

endmodule
`default_nettype wire
